// File: rtl/p405s_icu_pkg.sv
// p405s_icu_pkg: shared FSM encoding, line-offset width helper and reset vector for the ICU VA scheduler.
package p405s_icu_pkg;
  typedef enum logic [1:0] {INIT = 2'd0, IDLE = 2'd1, FILL = 2'd2, DONE = 2'd3} state_t;
  localparam logic [31:0] RESET_VEC_DEF = 32'hFFFF_FFFC;
  function automatic int off_w(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/p405s_icu_va_sched_if.sv
// p405s_icu_va_sched_if: fetch/fill requests in, VA register D/E1 and fill status out.
interface p405s_icu_va_sched_if;
  logic redirValid, seqReq, fetchStall, fillStart, fillWordAck;
  logic [0:31] redirAddr, fillAddr, vaL2, vaD;
  logic vaE1, fillBusy, fillDone, fillAbort, fillRej;
  modport master (
    output redirValid, redirAddr, seqReq, fetchStall, fillStart, fillAddr, fillWordAck, vaL2,
    input  vaD, vaE1, fillBusy, fillDone, fillAbort, fillRej
  );
  modport slave (
    input  redirValid, redirAddr, seqReq, fetchStall, fillStart, fillAddr, fillWordAck, vaL2,
    output vaD, vaE1, fillBusy, fillDone, fillAbort, fillRej
  );
endinterface

// File: rtl/p405s_icu_fillCnt.sv
// p405s_icu_fillCnt: fill beat counter with critical-word-first offset that wraps inside the line.
module p405s_icu_fillCnt
  import p405s_icu_pkg::*;
#(
  parameter int LINE_WORDS = 8,
  localparam int OW = off_w(LINE_WORDS)
) (
  input  logic          CB,
  input  logic          resetL,
  input  logic          i_load,
  input  logic [OW-1:0] i_start,
  input  logic          i_ack,
  output logic [OW-1:0] o_off,
  output logic          o_last
);
  logic [OW-1:0] r_cnt, r_start;
  assign o_off  = r_start + r_cnt + OW'(1);
  assign o_last = r_cnt == OW'(LINE_WORDS - 1);
  always_ff @(posedge CB or negedge resetL)
    if (!resetL) begin
      r_cnt   <= '0;
      r_start <= '0;
    end else if (i_load) begin
      r_cnt   <= '0;
      r_start <= i_start;
    end else if (i_ack) r_cnt <= r_cnt + OW'(1);
endmodule

// File: rtl/p405s_icu_va_sched.sv
// p405s_icu_va_sched: ICU VA register D/E1 arbiter (reset vector, redirect, line fill, sequential).
// ICU_NEXTLINE_PREFETCH_EN adds one automatic next-line prefetch fill after each demand fill.
module p405s_icu_va_sched
  import p405s_icu_pkg::*;
#(
  parameter int          INCR       = 8,
  parameter int          LINE_WORDS = 8,
  parameter logic [0:31] RESET_VEC  = RESET_VEC_DEF
) (
  input logic                 CB,
  input logic                 resetL,
  p405s_icu_va_sched_if.slave bus
);
  localparam int OW = off_w(LINE_WORDS);
  localparam int BW = 30 - OW;
  state_t r_state, w_nxt;
  logic [0:31] r_resume, w_d, w_redir;
  logic [0:BW-1] r_base, w_base_nx;
  logic [OW-1:0] w_sw, w_off;
  logic r_busy, r_done, r_abort, r_rej;
  logic w_e1, w_take, w_ack, w_last, w_pf_go, w_unused;
  assign w_redir   = {bus.redirAddr[0:29], 2'b00};
  assign w_take    = r_state == IDLE && !bus.redirValid && bus.fillStart;
  assign w_ack     = r_state == FILL && !bus.redirValid && bus.fillWordAck;
  assign w_base_nx = r_base + BW'(1);
  assign w_sw      = w_pf_go ? '0 : bus.fillAddr[BW:29];
  assign w_unused  = ^{bus.fillAddr[30:31], bus.redirAddr[30:31]};
`ifdef ICU_NEXTLINE_PREFETCH_EN
  logic r_pf;
  assign w_pf_go = r_state == DONE && !bus.redirValid && !r_pf;
`else
  assign w_pf_go = 1'b0;
`endif
  p405s_icu_fillCnt #(.LINE_WORDS(LINE_WORDS)) u_cnt (
    .CB     (CB),
    .resetL (resetL),
    .i_load (w_take || w_pf_go),
    .i_start(w_sw),
    .i_ack  (w_ack),
    .o_off  (w_off),
    .o_last (w_last)
  );
  always_comb begin
    w_d   = '0;
    w_e1  = 1'b0;
    w_nxt = r_state;
    case (r_state)
      INIT: begin
        w_d   = RESET_VEC;
        w_e1  = 1'b1;
        w_nxt = IDLE;
      end
      IDLE: begin
        w_e1  = bus.redirValid || bus.fillStart || (bus.seqReq && !bus.fetchStall);
        w_d   = bus.redirValid ? w_redir : bus.fillStart ? {bus.fillAddr[0:29], 2'b00} : bus.vaL2 + 32'(INCR);
        w_nxt = w_take ? FILL : IDLE;
      end
      FILL: begin
        w_e1  = bus.redirValid || (w_ack && !w_last);
        w_d   = bus.redirValid ? w_redir : {r_base, w_off, 2'b00};
        w_nxt = bus.redirValid ? IDLE : (w_ack && w_last) ? DONE : FILL;
      end
      default: begin
        w_e1  = 1'b1;
        w_d   = bus.redirValid ? w_redir : w_pf_go ? {w_base_nx, {(OW + 2){1'b0}}} : r_resume;
        w_nxt = w_pf_go ? FILL : IDLE;
      end
    endcase
  end
  // a dropped fillStart is any one not accepted by IDLE, except while INIT
  always_ff @(posedge CB or negedge resetL)
    if (!resetL) begin
      r_state  <= INIT;
      r_resume <= '0;
      r_base   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_abort  <= 1'b0;
      r_rej    <= 1'b0;
`ifdef ICU_NEXTLINE_PREFETCH_EN
      r_pf     <= 1'b0;
`endif
    end else begin
      r_state <= w_nxt;
      r_busy  <= w_nxt == FILL;
      r_done  <= r_state == DONE && !bus.redirValid && !w_pf_go;
      r_abort <= r_state == FILL && bus.redirValid;
      r_rej   <= bus.fillStart && (r_state == FILL || r_state == DONE || (r_state == IDLE && bus.redirValid));
      if (w_take) begin
        r_resume <= bus.vaL2;
        r_base   <= bus.fillAddr[0:BW-1];
      end
      if (w_pf_go) r_base <= w_base_nx;
`ifdef ICU_NEXTLINE_PREFETCH_EN
      r_pf <= w_pf_go ? 1'b1 : (w_nxt == IDLE) ? 1'b0 : r_pf;
`endif
    end
  assign bus.vaD       = resetL ? w_d : '0;
  assign bus.vaE1      = resetL && w_e1;
  assign bus.fillBusy  = r_busy;
  assign bus.fillDone  = r_done;
  assign bus.fillAbort = r_abort;
  assign bus.fillRej   = r_rej;
endmodule

// File: tb/tb_p405s_icu_va_sched.sv
// tb_p405s_icu_va_sched: directed bench for the ICU VA scheduler at default parameters.
module tb_p405s_icu_va_sched;
  logic CB = 1'b0;
  logic resetL = 1'b0;
  int n_chk = 0, n_pass = 0, n_fail = 0;
  p405s_icu_va_sched_if bus ();
  p405s_icu_va_sched dut (.CB(CB), .resetL(resetL), .bus(bus));
  always #5 CB = ~CB;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge CB);
    #1;
  endtask
  // non-final beats of an 8-word line starting at address a, then the silent last beat
  task automatic beats(input logic [31:0] a, input int from);
    for (int i = from; i < 7; i++) begin
      bus.fillWordAck = 1'b1;
      #1;
      chk("beat_va", bus.vaD, (a & 32'hFFFF_FFE0) | ((((a >> 2) + 32'(i) + 32'd1) & 32'h7) << 2));
      chk("beat_e1", 32'(bus.vaE1), 32'd1);
      tick;
    end
    bus.fillWordAck = 1'b1;
    #1;
    chk("last_e1", 32'(bus.vaE1), 32'd0);
    tick;
    bus.fillWordAck = 1'b0;
  endtask
  task automatic done_phase(input logic [31:0] line, input logic [31:0] resume);
`ifdef ICU_NEXTLINE_PREFETCH_EN
    #1;
    chk("pf_va", bus.vaD, (line & 32'hFFFF_FFE0) + 32'd32);
    tick;
    chk("pf_nodone", 32'(bus.fillDone), 32'd0);
    chk("pf_busy", 32'(bus.fillBusy), 32'd1);
    beats((line & 32'hFFFF_FFE0) + 32'd32, 0);
`endif
    #1;
    chk("resume_va", bus.vaD, resume);
    chk("resume_e1", 32'(bus.vaE1), 32'd1);
    chk("done_busy", 32'(bus.fillBusy), 32'd0);
    tick;
    chk("done_pulse", 32'(bus.fillDone), 32'd1);
    chk("idle_e1", 32'(bus.vaE1), 32'd0);
    tick;
    chk("done_clr", 32'(bus.fillDone), 32'd0);
  endtask
  initial begin
    bus.redirValid = 1'b0; bus.redirAddr = '0; bus.seqReq = 1'b0; bus.fetchStall = 1'b0;
    bus.fillStart = 1'b0; bus.fillAddr = '0; bus.fillWordAck = 1'b0; bus.vaL2 = '0;
    #1;
    chk("rst_e1", 32'(bus.vaE1), 32'd0);
    chk("rst_va", bus.vaD, 32'd0);
    chk("rst_busy", 32'(bus.fillBusy), 32'd0);
    chk("rst_done", 32'(bus.fillDone), 32'd0);
    chk("rst_abort", 32'(bus.fillAbort), 32'd0);
    chk("rst_rej", 32'(bus.fillRej), 32'd0);
    tick;
    tick;
    resetL = 1'b1;
    bus.fillStart = 1'b1;
    #1;
    chk("init_va", bus.vaD, 32'hFFFF_FFFC);
    chk("init_e1", 32'(bus.vaE1), 32'd1);
    tick;
    bus.fillStart = 1'b0;
    #1;
    chk("idle_e1", 32'(bus.vaE1), 32'd0);
    chk("init_norej", 32'(bus.fillRej), 32'd0);
    chk("init_nobusy", 32'(bus.fillBusy), 32'd0);
    bus.vaL2 = 32'h0000_1000; bus.seqReq = 1'b1;
    #1;
    chk("seq_va", bus.vaD, 32'h0000_1008);
    chk("seq_e1", 32'(bus.vaE1), 32'd1);
    bus.vaL2 = 32'hFFFF_FFF8;
    #1;
    chk("seq_wrap", bus.vaD, 32'h0000_0000);
    bus.fetchStall = 1'b1;
    #1;
    chk("stall_e1", 32'(bus.vaE1), 32'd0);
    bus.seqReq = 1'b0; bus.fetchStall = 1'b0;
    bus.vaL2 = 32'h0000_2000; bus.fillStart = 1'b1; bus.fillAddr = 32'h0000_3014;
    #1;
    chk("fill_va0", bus.vaD, 32'h0000_3014);
    chk("fill_e1", 32'(bus.vaE1), 32'd1);
    tick;
    bus.fillStart = 1'b0;
    chk("fill_busy", 32'(bus.fillBusy), 32'd1);
    bus.seqReq = 1'b1;
    #1;
    chk("fill_seq_ign", 32'(bus.vaE1), 32'd0);
    bus.seqReq = 1'b0;
    beats(32'h0000_3014, 0);
    done_phase(32'h0000_3014, 32'h0000_2000);
    bus.vaL2 = 32'h0000_5000; bus.fillStart = 1'b1; bus.fillAddr = 32'h0000_3000;
    tick;
    bus.fillStart = 1'b0; bus.fillWordAck = 1'b1;
    tick;
    tick;
    tick;
    bus.fillWordAck = 1'b0; bus.redirValid = 1'b1; bus.redirAddr = 32'h0000_4003;
    #1;
    chk("abort_va", bus.vaD, 32'h0000_4000);
    chk("abort_e1", 32'(bus.vaE1), 32'd1);
    tick;
    bus.redirValid = 1'b0;
    chk("abort_pulse", 32'(bus.fillAbort), 32'd1);
    chk("abort_busy", 32'(bus.fillBusy), 32'd0);
    chk("abort_nodone", 32'(bus.fillDone), 32'd0);
    tick;
    chk("abort_clr", 32'(bus.fillAbort), 32'd0);
    chk("abort_nodone2", 32'(bus.fillDone), 32'd0);
    chk("abort_idle_e1", 32'(bus.vaE1), 32'd0);
    bus.redirValid = 1'b1; bus.redirAddr = 32'h0000_6008; bus.fillStart = 1'b1; bus.fillAddr = 32'h0000_7000;
    #1;
    chk("race_va", bus.vaD, 32'h0000_6008);
    tick;
    bus.redirValid = 1'b0; bus.fillStart = 1'b0;
    chk("race_rej", 32'(bus.fillRej), 32'd1);
    chk("race_nobusy", 32'(bus.fillBusy), 32'd0);
    tick;
    chk("race_rej_clr", 32'(bus.fillRej), 32'd0);
    bus.vaL2 = 32'h0000_2000; bus.fillStart = 1'b1; bus.fillAddr = 32'h0000_3014;
    tick;
    bus.fillAddr = 32'h0000_8000; bus.fillWordAck = 1'b1;
    #1;
    chk("rej_fill_va", bus.vaD, 32'h0000_3018);
    tick;
    bus.fillStart = 1'b0; bus.fillWordAck = 1'b0;
    chk("fill_rej", 32'(bus.fillRej), 32'd1);
    chk("fill_rej_busy", 32'(bus.fillBusy), 32'd1);
    beats(32'h0000_3014, 1);
    done_phase(32'h0000_3014, 32'h0000_2000);
    bus.fillStart = 1'b1; bus.fillAddr = 32'h0000_3000;
    tick;
    bus.fillStart = 1'b0; bus.fillWordAck = 1'b1;
    tick;
    tick;
    bus.fillWordAck = 1'b0;
    resetL = 1'b0;
    #1;
    chk("mid_rst_e1", 32'(bus.vaE1), 32'd0);
    chk("mid_rst_va", bus.vaD, 32'd0);
    chk("mid_rst_busy", 32'(bus.fillBusy), 32'd0);
    chk("mid_rst_rej", 32'(bus.fillRej), 32'd0);
    tick;
    resetL = 1'b1;
    #1;
    chk("reinit_va", bus.vaD, 32'hFFFF_FFFC);
    chk("reinit_e1", 32'(bus.vaE1), 32'd1);
    tick;
    chk("reinit_idle", 32'(bus.vaE1), 32'd0);
    chk("reinit_busy", 32'(bus.fillBusy), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
